// File: rtl/lfsr_seed_rng_if.sv
// Seed / random-value bus between the seed-select mux, lfsr_seed_rng and its consumer.
// Optional `wrapped` signal exists only when LFSR_WRAP_DETECT_EN is defined.
interface lfsr_seed_rng_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] seed;
  logic             load;
  logic             rnd_ready;
  logic [WIDTH-1:0] rnd;
  logic             rnd_valid;
  logic             busy;
`ifdef LFSR_WRAP_DETECT_EN
  logic             wrapped;
`endif

`ifdef LFSR_WRAP_DETECT_EN
  // Seed source and value consumer side
  modport master (
    output seed, load, rnd_ready,
    input  rnd, rnd_valid, busy, wrapped
  );

  // Generator side
  modport slave (
    input  seed, load, rnd_ready,
    output rnd, rnd_valid, busy, wrapped
  );
`else
  // Seed source and value consumer side
  modport master (
    output seed, load, rnd_ready,
    input  rnd, rnd_valid, busy
  );

  // Generator side
  modport slave (
    input  seed, load, rnd_ready,
    output rnd, rnd_valid, busy
  );
`endif
endinterface

// File: rtl/lfsr_seed_rng.sv
// Seeded Fibonacci LFSR random-number generator with optional warm-up and a
// valid/ready output. Define LFSR_WRAP_DETECT_EN to add the full-period
// `wrapped` pulse and the captured-seed register it compares against.
module lfsr_seed_rng #(
  parameter int unsigned     WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'h1D),
  parameter int unsigned     WARMUP   = 4,
  parameter logic [WIDTH-1:0] ZERO_SUB = WIDTH'(8'h01)
) (
  input  logic           clk,
  input  logic           reset,
  lfsr_seed_rng_if.slave bus
);

  localparam int unsigned     CNT_W     = 8;
  localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(WARMUP);
  localparam bit              WARM_EN   = (WARMUP != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           r_fsm;
  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_busy;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;
  logic             w_step;

  // Feedback is the parity of the tapped bits, shifted in at the MSB
  assign w_fb   = ^(r_lfsr & TAPS);
  assign w_next = {w_fb, r_lfsr[WIDTH-1:1]};

  // An all-zero seed would lock the LFSR, so it is replaced
  assign w_seed = (bus.seed == '0) ? ZERO_SUB : bus.seed;

  // A step happens every warm-up cycle or on a handshake, never alongside a load
  assign w_step = !bus.load &&
                  ((r_fsm == ST_WARM) || ((r_fsm == ST_RUN) && r_valid && bus.rnd_ready));

  // Control FSM, LFSR state and warm-up counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= ST_IDLE;
      r_lfsr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (bus.load) begin
      r_lfsr  <= w_seed;
      r_cnt   <= WARM_INIT;
      r_fsm   <= WARM_EN ? ST_WARM : ST_RUN;
      r_valid <= !WARM_EN;
      r_busy  <= WARM_EN;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        ST_WARM: begin
          r_lfsr <= w_next;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
          // Counter at 1 (or defensively 0) means this is the last warm-up step
          if (r_cnt <= CNT_W'(1)) begin
            r_fsm   <= ST_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_step) begin
            r_lfsr <= w_next;
          end
        end
        default: begin
          r_fsm   <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rnd       = r_lfsr;
  assign bus.rnd_valid = r_valid;
  assign bus.busy      = r_busy;

`ifdef LFSR_WRAP_DETECT_EN
  logic [WIDTH-1:0] r_seed_cap;
  logic             r_wrapped;

  // Remember the effective seed and flag the step that returns to it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seed_cap <= '0;
      r_wrapped  <= 1'b0;
    end else if (bus.load) begin
      r_seed_cap <= w_seed;
      r_wrapped  <= 1'b0;
    end else begin
      r_wrapped  <= w_step && (w_next == r_seed_cap);
    end
  end

  assign bus.wrapped = r_wrapped;
`endif

endmodule

// File: tb/tb_lfsr_seed_rng.sv
// Self-checking bench for lfsr_seed_rng: one instance with WARMUP=0 and one
// with WARMUP=4 share clock and stimulus; both are compared every cycle to a
// behavioural model. Define LFSR_WRAP_DETECT_EN to also check `wrapped`.
module tb_lfsr_seed_rng;

  localparam logic [7:0] TAPS = 8'h1D;

  logic clk;
  logic reset;

  int n_vec;
  int n_err;

  lfsr_seed_rng_if #(.WIDTH(8)) bus0 ();
  lfsr_seed_rng_if #(.WIDTH(8)) bus1 ();

  lfsr_seed_rng #(.WIDTH(8), .TAPS(8'h1D), .WARMUP(0), .ZERO_SUB(8'h01)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  lfsr_seed_rng #(.WIDTH(8), .TAPS(8'h1D), .WARMUP(4), .ZERO_SUB(8'h01)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: value, remaining warm-up steps, run flag, captured seed, wrap flag
  logic [7:0] m_val  [2];
  logic [7:0] m_cap  [2];
  int         m_warm [2];
  bit         m_run  [2];
  bit         m_wrap [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int warmup_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  // Parity of tapped bits becomes the new top bit after a right shift
  function automatic logic [7:0] model_step(input logic [7:0] v);
    int par;
    par = 0;
    for (int i = 0; i < 8; i++) begin
      if (TAPS[i] && v[i]) par = par ^ 1;
    end
    return (v >> 1) + ((par != 0) ? 8'd128 : 8'd0);
  endfunction

  task automatic model_edge(input int d, input bit rst, input bit ld,
                            input logic [7:0] sd, input bit rdy);
    if (rst) begin
      m_val[d] = 8'h00; m_cap[d] = 8'h00; m_warm[d] = 0; m_run[d] = 0; m_wrap[d] = 0;
    end else if (ld) begin
      m_val[d]  = (sd == 8'h00) ? 8'h01 : sd;
      m_cap[d]  = m_val[d];
      m_warm[d] = warmup_of(d);
      m_run[d]  = (warmup_of(d) == 0);
      m_wrap[d] = 0;
    end else if (m_warm[d] > 0) begin
      m_val[d]  = model_step(m_val[d]);
      m_warm[d] = m_warm[d] - 1;
      if (m_warm[d] == 0) m_run[d] = 1;
      m_wrap[d] = (m_val[d] == m_cap[d]);
    end else if (m_run[d] && rdy) begin
      m_val[d]  = model_step(m_val[d]);
      m_wrap[d] = (m_val[d] == m_cap[d]);
    end else begin
      m_wrap[d] = 0;
    end
  endtask

  // Apply one cycle of stimulus to both instances and compare all outputs
  task automatic cycle(input bit rst, input bit ld, input logic [7:0] sd, input bit rdy);
    reset          = rst;
    bus0.load      = ld;  bus1.load      = ld;
    bus0.seed      = sd;  bus1.seed      = sd;
    bus0.rnd_ready = rdy; bus1.rnd_ready = rdy;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, rst, ld, sd, rdy);
    #1;
    check("rnd0",   32'(bus0.rnd),       32'(m_val[0]));
    check("valid0", 32'(bus0.rnd_valid), 32'(m_run[0] && (m_warm[0] == 0)));
    check("busy0",  32'(bus0.busy),      32'(m_warm[0] > 0));
    check("rnd1",   32'(bus1.rnd),       32'(m_val[1]));
    check("valid1", 32'(bus1.rnd_valid), 32'(m_run[1] && (m_warm[1] == 0)));
    check("busy1",  32'(bus1.busy),      32'(m_warm[1] > 0));
`ifdef LFSR_WRAP_DETECT_EN
    check("wrap0",  32'(bus0.wrapped),   32'(m_wrap[0]));
    check("wrap1",  32'(bus1.wrapped),   32'(m_wrap[1]));
`endif
  endtask

  initial begin
    logic [7:0] exp_seq [5];
    int         wraps;
    bit         r_ld;
    bit         r_rst;
    logic [7:0] r_sd;

    n_vec = 0;
    n_err = 0;
    exp_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    reset = 1'b1;
    bus0.load = 1'b0; bus1.load = 1'b0;
    bus0.seed = 8'h00; bus1.seed = 8'h00;
    bus0.rnd_ready = 1'b0; bus1.rnd_ready = 1'b0;
    for (int d = 0; d < 2; d++) model_edge(d, 1'b1, 1'b0, 8'h00, 1'b0);

    // Reset overrides a simultaneous load
    repeat (2) begin
      cycle(1'b1, 1'b1, 8'h55, 1'b0);
      check("rst_rnd", 32'(bus0.rnd), 32'h0);
      check("rst_busy", 32'(bus1.busy), 32'h0);
    end

    // WARMUP=0 sequence from seed 01
    cycle(1'b0, 1'b1, 8'h01, 1'b1);
    check("seq_first", 32'(bus0.rnd), 32'h01);
    check("seq_valid", 32'(bus0.rnd_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check("seq", 32'(bus0.rnd), 32'(exp_seq[i]));
    end

    // Warm-up restarted by a second load
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h02, 1'b0);
    check("restart_busy", 32'(bus1.busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("restart_busy", 32'(bus1.busy), 32'h1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("restart_done", 32'(bus1.rnd_valid), 32'h1);

    // Plain warm-up from 01 ends on 10
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("warm_val", 32'(bus1.rnd), 32'h10);
    check("warm_valid", 32'(bus1.rnd_valid), 32'h1);

    // Backpressure holds the value
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("bp_hold", 32'(bus0.rnd), 32'h80);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("bp_release", 32'(bus0.rnd), 32'h40);

    // Zero seed substitution, then load colliding with a handshake
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("zero_sub", 32'(bus0.rnd), 32'h01);
    cycle(1'b0, 1'b1, 8'hAA, 1'b1);
    check("collide", 32'(bus0.rnd), 32'hAA);

    // Full period: 255 handshakes return to the seed
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h01, 1'b1);
    wraps = 0;
    for (int i = 0; i < 255; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
`ifdef LFSR_WRAP_DETECT_EN
      if (bus0.wrapped) wraps++;
`endif
    end
    check("period", 32'(bus0.rnd), 32'h01);
`ifdef LFSR_WRAP_DETECT_EN
    check("wrap_count", 32'(wraps), 32'd1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      r_ld  = ($urandom_range(0, 11) == 0);
      r_sd  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      cycle(r_rst, r_ld, r_sd, ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
